pipe_hazard_unit: RTL and testbench

//  Hazard/sequencing controller for the 5-stage pipeline (F,D,E,M,W). Drives stall/flush of every

---
 rtl/pipe_hazard_pkg.sv | 32 +++
 rtl/pipe_hazard_unit_if.sv | 31 +++
 rtl/pipe_hazard_unit_mem_wait_fsm.sv | 54 +++++
 rtl/pipe_hazard_unit.sv | 91 +++++++++
 tb/tb_pipe_hazard_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/sequencing controller.
package pipe_hazard_pkg;

  // Register index of the PC (R15); never a forwarding source.
  localparam logic [3:0] REG_PC = 4'hF;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Operand select for one E-stage source; the younger M result wins over W.
  function automatic fwd_sel_t fwd_sel(
    input logic [3:0] ra,
    input logic       rw_m,
    input logic [3:0] wa_m,
    input logic       rw_w,
    input logic [3:0] wa_w
  );
    if (rw_m && (ra == wa_m) && (wa_m != REG_PC))      return FWD_MEM;
    else if (rw_w && (ra == wa_w) && (wa_w != REG_PC)) return FWD_WB;
    else                                               return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle. master = pipeline side, slave = hazard unit.
interface pipe_hazard_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic [3:0]       RA1D, RA2D, RA1E, RA2E;
  logic [3:0]       WA3E, WA3M, WA3W;
  logic             MemtoRegE, RegWriteM, RegWriteW;
  logic             MemtoRegM, MemWriteM;
  logic             PCSrcD, PCSrcE, PCSrcM, BranchTakenE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             MemDoneM;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output MemtoRegE, RegWriteM, RegWriteW, MemtoRegM, MemWriteM,
    output PCSrcD, PCSrcE, PCSrcM, BranchTakenE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemDoneM, StallCnt, FlushCnt
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  MemtoRegE, RegWriteM, RegWriteW, MemtoRegM, MemWriteM,
    input  PCSrcD, PCSrcE, PCSrcM, BranchTakenE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemDoneM, StallCnt, FlushCnt
  );
endinterface

// File: rtl/pipe_hazard_unit_mem_wait_fsm.sv
// Wait-state sequencer for a multi-cycle data-memory access held in M.
// The access-detect cycle in IDLE is itself the first wait state, so WAIT
// covers the remaining MEM_LAT-1 cycles and each access stalls exactly MEM_LAT.
module mem_wait_fsm
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic MemAcc,
  output logic MemStall,
  output logic MemDoneM
);

  localparam int unsigned CW       = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned LOAD_VAL = (MEM_LAT >= 2) ? (MEM_LAT - 2) : 0;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_VAL);

  mem_state_t      state;
  logic [CW-1:0]   cnt;

  // State and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MemAcc && (MEM_LAT != 0)) begin
            if (MEM_LAT == 1) begin
              state <= DONE;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - CW'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Mealy outputs, forced low while reset is asserted.
  assign MemStall = !rst && (((state == IDLE) && MemAcc && (MEM_LAT != 0)) || (state == WAIT));
  assign MemDoneM = !rst && ((state == DONE) || ((MEM_LAT == 0) && MemAcc));

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/sequencing controller for the F,D,E,M,W pipeline: forwarding selects,
// stall/flush controls and an M-stage wait-state sequencer.
// Optional: define HAZARD_PERF_EN for saturating stall/flush performance counters.
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_unit_if.slave  hz
);

  logic mem_acc, mem_stall, mem_done;
  logic ld_stall, pc_pend;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;

  assign mem_acc = hz.MemtoRegM | hz.MemWriteM;

  mem_wait_fsm #(.MEM_LAT(MEM_LAT)) u_mem_wait (
    .clk      (clk),
    .rst      (rst),
    .MemAcc   (mem_acc),
    .MemStall (mem_stall),
    .MemDoneM (mem_done)
  );

  // Forwarding selects for both E operands.
  always_comb begin
    hz.ForwardAE = fwd_sel(hz.RA1E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);
    hz.ForwardBE = fwd_sel(hz.RA2E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);
  end

  // Hazard combine; a memory wait freezes F..M and masks every other hazard.
  always_comb begin
    ld_stall = hz.MemtoRegE && ((hz.RA1D == hz.WA3E) || (hz.RA2D == hz.WA3E));
    pc_pend  = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_w  = 1'b0;
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      stall_f = ld_stall | pc_pend;
      stall_d = ld_stall;
      flush_d = pc_pend | hz.BranchTakenE;
      flush_e = ld_stall | hz.BranchTakenE;
    end
  end

  assign hz.StallF   = stall_f;
  assign hz.StallD   = stall_d;
  assign hz.StallE   = stall_e;
  assign hz.StallM   = stall_m;
  assign hz.FlushD   = flush_d;
  assign hz.FlushE   = flush_e;
  assign hz.FlushW   = flush_w;
  assign hz.MemDoneM = mem_done;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // Saturating stall/flush event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && (stall_cnt != '1))              stall_cnt <= stall_cnt + CNT_W'(1);
      if ((flush_d || flush_e) && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.StallCnt = stall_cnt;
  assign hz.FlushCnt = flush_cnt;
`else
  assign hz.StallCnt = CNT_W'(0);
  assign hz.FlushCnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Randomized self-checking bench: a MEM_LAT=2 and a MEM_LAT=0 instance share
// the same stimulus and are compared against a cycle-level reference model.
module tb_pipe_hazard_unit;

`ifdef HAZARD_PERF_EN
  localparam int unsigned CW = 6;
`else
  localparam int unsigned CW = 32;
`endif
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_unit_if #(.CNT_W(CW)) hif0 ();
  pipe_hazard_unit_if #(.CNT_W(CW)) hif1 ();

  pipe_hazard_unit #(.MEM_LAT(2), .CNT_W(CW)) dut0 (.clk(clk), .rst(rst), .hz(hif0));
  pipe_hazard_unit #(.MEM_LAT(0), .CNT_W(CW)) dut1 (.clk(clk), .rst(rst), .hz(hif1));

  // Second instance sees exactly the same pipeline inputs.
  assign hif1.RA1D = hif0.RA1D;           assign hif1.RA2D = hif0.RA2D;
  assign hif1.RA1E = hif0.RA1E;           assign hif1.RA2E = hif0.RA2E;
  assign hif1.WA3E = hif0.WA3E;           assign hif1.WA3M = hif0.WA3M;
  assign hif1.WA3W = hif0.WA3W;           assign hif1.MemtoRegE = hif0.MemtoRegE;
  assign hif1.RegWriteM = hif0.RegWriteM; assign hif1.RegWriteW = hif0.RegWriteW;
  assign hif1.MemtoRegM = hif0.MemtoRegM; assign hif1.MemWriteM = hif0.MemWriteM;
  assign hif1.PCSrcD = hif0.PCSrcD;       assign hif1.PCSrcE = hif0.PCSrcE;
  assign hif1.PCSrcM = hif0.PCSrcM;       assign hif1.BranchTakenE = hif0.BranchTakenE;

  int checks = 0;
  int errors = 0;

  // Reference state per instance: remaining wait cycles after the current one,
  // a pending "data valid" cycle, and the event counters.
  int      lat   [2] = '{2, 0};
  int      busy  [2];
  bit      dflag [2];
  longint  scnt  [2];
  longint  fcnt  [2];
  bit      exp_sf[2];
  bit      exp_fl[2];
  longint  cmax = (longint'(1) << CW) - 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
    if (hif0.RegWriteM && ra == hif0.WA3M && hif0.WA3M != 4'hF) return 2'b10;
    if (hif0.RegWriteW && ra == hif0.WA3W && hif0.WA3W != 4'hF) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      busy[d] = 0; dflag[d] = 0; scnt[d] = 0; fcnt[d] = 0;
    end
  endtask

  task automatic check_all();
    bit acc, ld, pc, br, ms, md;
    bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;
    logic [1:0] fa, fb;
    logic s_f, s_d, s_e, s_m, f_d, f_e, f_w, m_d;
    logic [CW-1:0] sc, fc;
    acc = hif0.MemtoRegM | hif0.MemWriteM;
    ld  = hif0.MemtoRegE && (hif0.RA1D == hif0.WA3E || hif0.RA2D == hif0.WA3E);
    pc  = hif0.PCSrcD | hif0.PCSrcE | hif0.PCSrcM;
    br  = hif0.BranchTakenE;
    for (int d = 0; d < 2; d++) begin
      ms = !rst && (busy[d] > 0 || (!dflag[d] && acc && lat[d] != 0));
      md = !rst && (dflag[d] || (lat[d] == 0 && acc));
      if (ms) begin
        {e_sf, e_sd, e_se, e_sm, e_fw, e_fd, e_fe} = 7'b1111100;
      end else begin
        e_sf = ld | pc; e_sd = ld; e_se = 0; e_sm = 0; e_fw = 0;
        e_fd = pc | br; e_fe = ld | br;
      end
      exp_sf[d] = e_sf;
      exp_fl[d] = e_fd | e_fe;
      fa  = d ? hif1.ForwardAE : hif0.ForwardAE;
      fb  = d ? hif1.ForwardBE : hif0.ForwardBE;
      s_f = d ? hif1.StallF : hif0.StallF;
      s_d = d ? hif1.StallD : hif0.StallD;
      s_e = d ? hif1.StallE : hif0.StallE;
      s_m = d ? hif1.StallM : hif0.StallM;
      f_d = d ? hif1.FlushD : hif0.FlushD;
      f_e = d ? hif1.FlushE : hif0.FlushE;
      f_w = d ? hif1.FlushW : hif0.FlushW;
      m_d = d ? hif1.MemDoneM : hif0.MemDoneM;
      sc  = d ? hif1.StallCnt : hif0.StallCnt;
      fc  = d ? hif1.FlushCnt : hif0.FlushCnt;
      check($sformatf("d%0d ForwardAE", d), 64'(fa), 64'(ref_fwd(hif0.RA1E)));
      check($sformatf("d%0d ForwardBE", d), 64'(fb), 64'(ref_fwd(hif0.RA2E)));
      check($sformatf("d%0d StallF", d), 64'(s_f), 64'(e_sf));
      check($sformatf("d%0d StallD", d), 64'(s_d), 64'(e_sd));
      check($sformatf("d%0d StallE", d), 64'(s_e), 64'(e_se));
      check($sformatf("d%0d StallM", d), 64'(s_m), 64'(e_sm));
      check($sformatf("d%0d FlushD", d), 64'(f_d), 64'(e_fd));
      check($sformatf("d%0d FlushE", d), 64'(f_e), 64'(e_fe));
      check($sformatf("d%0d FlushW", d), 64'(f_w), 64'(e_fw));
      check($sformatf("d%0d MemDoneM", d), 64'(m_d), 64'(md));
`ifdef HAZARD_PERF_EN
      check($sformatf("d%0d StallCnt", d), 64'(sc), 64'(scnt[d]));
      check($sformatf("d%0d FlushCnt", d), 64'(fc), 64'(fcnt[d]));
`else
      check($sformatf("d%0d StallCnt", d), 64'(sc), 64'd0);
      check($sformatf("d%0d FlushCnt", d), 64'(fc), 64'd0);
`endif
    end
  endtask

  task automatic model_advance();
    bit acc;
    acc = hif0.MemtoRegM | hif0.MemWriteM;
    for (int d = 0; d < 2; d++) begin
      if (exp_sf[d] && scnt[d] < cmax) scnt[d]++;
      if (exp_fl[d] && fcnt[d] < cmax) fcnt[d]++;
      if (busy[d] > 0) begin
        busy[d]--;
        if (busy[d] == 0) dflag[d] = 1;
      end else if (dflag[d]) begin
        dflag[d] = 0;
      end else if (acc && lat[d] != 0) begin
        busy[d] = lat[d] - 1;
        if (busy[d] == 0) dflag[d] = 1;
      end
    end
  endtask

  // One clock: inputs already applied after the falling edge.
  task automatic step();
    if (rst) model_reset();
    #1;
    check_all();
    @(posedge clk);
    if (!rst) model_advance();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {hif0.RA1D, hif0.RA2D, hif0.RA1E, hif0.RA2E} = '0;
    {hif0.WA3E, hif0.WA3M, hif0.WA3W} = {4'd14, 4'd14, 4'd14};
    {hif0.MemtoRegE, hif0.RegWriteM, hif0.RegWriteW, hif0.MemtoRegM, hif0.MemWriteM} = '0;
    {hif0.PCSrcD, hif0.PCSrcE, hif0.PCSrcM, hif0.BranchTakenE} = '0;
  endtask

  function automatic logic [3:0] rreg();
    int v;
    v = $urandom_range(0, 4);
    return (v == 4) ? 4'hF : 4'(v);
  endfunction

  task automatic rand_inputs();
    hif0.RA1D = rreg(); hif0.RA2D = rreg(); hif0.RA1E = rreg(); hif0.RA2E = rreg();
    hif0.WA3E = rreg(); hif0.WA3M = rreg(); hif0.WA3W = rreg();
    hif0.MemtoRegE = ($urandom_range(0, 3) == 0);
    hif0.RegWriteM = $urandom_range(0, 1); hif0.RegWriteW = $urandom_range(0, 1);
    hif0.MemtoRegM = ($urandom_range(0, 4) == 0);
    hif0.MemWriteM = ($urandom_range(0, 6) == 0);
    hif0.PCSrcD = ($urandom_range(0, 7) == 0); hif0.PCSrcE = ($urandom_range(0, 7) == 0);
    hif0.PCSrcM = ($urandom_range(0, 7) == 0);
    hif0.BranchTakenE = ($urandom_range(0, 7) == 0);
    rst = ($urandom_range(0, 149) == 0);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    step();
    step();
    rst = 1'b0;
    step();

    // Forwarding: M wins over W; R15 in M falls back to W only if W enabled.
    hif0.RegWriteM = 1; hif0.WA3M = 3; hif0.RA1E = 3; hif0.RegWriteW = 1; hif0.WA3W = 3;
    step();
    hif0.WA3M = 15; hif0.RegWriteW = 0;
    step();
    clear_inputs();

    // Load-use hazard.
    hif0.MemtoRegE = 1; hif0.WA3E = 5; hif0.RA2D = 5;
    step();
    clear_inputs();

    // PC write travelling D, E, M, then a taken branch.
    hif0.PCSrcD = 1; step(); clear_inputs();
    hif0.PCSrcE = 1; step(); clear_inputs();
    hif0.PCSrcM = 1; step(); clear_inputs();
    hif0.BranchTakenE = 1; step(); clear_inputs();

    // Load in M held while frozen, then back-to-back, plus hazards masked during wait.
    hif0.MemtoRegM = 1; hif0.PCSrcD = 1; hif0.BranchTakenE = 1;
    for (int i = 0; i < 5; i++) step();
    clear_inputs();
    step();

    // Reset asserted mid-wait, then released.
    hif0.MemWriteM = 1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_inputs();
    step();
    step();

    for (int i = 0; i < NCYC; i++) begin
      rand_inputs();
      step();
    end
    rst = 1'b0;
    clear_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
